// File: rtl/add_acc_pipe.sv
// Two-stage valid/ready arithmetic unit: add-with-carry, subtract-with-borrow,
// saturating add and a running accumulator, one beat per cycle.
module add_acc_pipe #(
    parameter int WIDTH = 4,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       mode,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             flag_c,
    output logic [ACC_W-1:0] acc_val
);
    localparam logic [1:0] M_ADD = 2'b00;
    localparam logic [1:0] M_SUB = 2'b01;
    localparam logic [1:0] M_ACC = 2'b10;
    localparam logic [1:0] M_SAT = 2'b11;
    localparam int AW1 = ACC_W + 1;

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;
    logic [1:0]       s1_mode_q;
    logic             out_valid_q;
    logic [ACC_W-1:0] result_q, result_d;
    logic             flag_q, flag_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_base;
    logic [WIDTH:0]   sum_w, diff_w;
    logic [ACC_W:0]   acc_sum;
    logic             s1_load, s2_load;

    assign s2_load   = ~out_valid_q | out_ready;
    assign s1_load   = ~s1_valid_q | s2_load;
    assign in_ready  = s1_load;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_c    = flag_q;
    assign acc_val   = acc_q;

    always_comb begin
        sum_w    = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        diff_w   = {1'b0, s1_a_q} - {1'b0, s1_b_q};
        // A clear arriving with an ACC beat acts first, so the beat starts from zero.
        acc_base = acc_clr ? '0 : acc_q;
        acc_sum  = {1'b0, acc_base} + AW1'(sum_w);
        result_d = '0;
        flag_d   = 1'b0;
        case (s1_mode_q)
            M_ADD: begin
                result_d = ACC_W'(sum_w);
                flag_d   = sum_w[WIDTH];
            end
            M_SUB: begin
                result_d = ACC_W'(diff_w[WIDTH-1:0]);
                flag_d   = diff_w[WIDTH];
            end
            M_ACC: begin
                result_d = acc_sum[ACC_W-1:0];
                flag_d   = acc_sum[ACC_W];
            end
            M_SAT: begin
                result_d = sum_w[WIDTH] ? ACC_W'({WIDTH{1'b1}}) : ACC_W'(sum_w[WIDTH-1:0]);
                flag_d   = sum_w[WIDTH];
            end
            default: ;
        endcase
        acc_d = acc_q;
        if (s2_load && s1_valid_q && s1_mode_q == M_ACC)
            acc_d = acc_sum[ACC_W-1:0];
        else if (acc_clr)
            acc_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_mode_q  <= M_ADD;
        end else if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_a_q    <= op_a;
                s1_b_q    <= op_b;
                s1_mode_q <= mode;
            end
        end
    end

    // An empty stage1 on a load drops out_valid but leaves result/flag untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flag_q      <= 1'b0;
        end else if (s2_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                result_q <= result_d;
                flag_q   <= flag_d;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end
endmodule

// File: tb/tb_add_acc_pipe.sv
// Bench for add_acc_pipe: table-driven vectors through a scoreboard queue plus
// hand-written stall, accumulator-clear and mid-flight reset sequences.
module tb_add_acc_pipe;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] op_a = '0, op_b = '0;
    logic [1:0] mode = '0;
    logic       acc_clr = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] result, acc_val;
    logic       flag_c;

    add_acc_pipe #(.WIDTH(4), .ACC_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .mode(mode), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_c(flag_c), .acc_val(acc_val)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] r; logic f; } exp_t;
    typedef struct { logic [1:0] m; logic [3:0] a; logic [3:0] b; logic [7:0] r; logic f; } vec_t;

    exp_t sb[$];
    exp_t pend;
    vec_t tbl[12];
    int   nchk = 0, nerr = 0, nsent = 0, nret = 0;
    bit   took;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: retire/compare at the negedge, record acceptance, step past the posedge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_result", {24'd0, result}, {24'd0, e.r});
                chk("sb_flag", {31'd0, flag_c}, {31'd0, e.f});
                nret++;
            end
        end
        took = in_valid && in_ready;
        if (took) begin
            sb.push_back(pend);
            nsent++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] r, input logic f, input bit unstick);
        in_valid = 1'b1; mode = m; op_a = a; op_b = b;
        pend.r = r; pend.f = f;
        took = 1'b0;
        for (int k = 0; k < 50 && !took; k++) begin
            tick();
            if (!took && unstick) out_ready = 1'b1;
        end
        if (!took) chk("send_timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 60 && sb.size() > 0; k++) tick();
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    task automatic acc_clear();
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        chk("acc_clear", {24'd0, acc_val}, 32'd0);
    endtask

    task automatic latency_add_f1();
        out_ready = 1'b1;
        send(2'b00, 4'hF, 4'h1, 8'h10, 1'b1, 1'b0);
        chk("lat_n1_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("lat_n2_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_n2_result", {24'd0, result}, 32'h10);
        chk("lat_n2_flag", {31'd0, flag_c}, 32'd1);
        drain();
    endtask

    initial begin
        tbl[0]  = '{2'b00, 4'hF, 4'h1, 8'h10, 1'b1};
        tbl[1]  = '{2'b00, 4'h0, 4'h0, 8'h00, 1'b0};
        tbl[2]  = '{2'b00, 4'h7, 4'h8, 8'h0F, 1'b0};
        tbl[3]  = '{2'b00, 4'hF, 4'hF, 8'h1E, 1'b1};
        tbl[4]  = '{2'b01, 4'h3, 4'h5, 8'h0E, 1'b1};
        tbl[5]  = '{2'b01, 4'h5, 4'h3, 8'h02, 1'b0};
        tbl[6]  = '{2'b01, 4'h0, 4'hF, 8'h01, 1'b1};
        tbl[7]  = '{2'b01, 4'h7, 4'h7, 8'h00, 1'b0};
        tbl[8]  = '{2'b11, 4'h9, 4'h8, 8'h0F, 1'b1};
        tbl[9]  = '{2'b11, 4'h3, 4'h4, 8'h07, 1'b0};
        tbl[10] = '{2'b11, 4'hF, 4'h0, 8'h0F, 1'b0};
        tbl[11] = '{2'b11, 4'hF, 4'hF, 8'h0F, 1'b1};

        // Reset state
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_flag", {31'd0, flag_c}, 32'd0);
        chk("rst_acc", {24'd0, acc_val}, 32'd0);
        tick(); tick();
        reset = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        latency_add_f1();

        // Table, back-to-back then with random downstream stalls
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 12; i++) begin
                out_ready = (p == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                send(tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].f, 1'b1);
            end
            drain();
        end

        // Accumulator run with wrap on the ninth beat
        acc_clear();
        for (int i = 0; i < 9; i++) begin
            int e;
            e = (i + 1) * 30;
            send(2'b10, 4'hF, 4'hF, e[7:0], e >= 256, 1'b0);
        end
        drain();
        chk("acc_wrap_val", {24'd0, acc_val}, 32'h0E);

        // Stall: two accepts fill both stages, third waits
        out_ready = 1'b0;
        send(2'b00, 4'h1, 4'h2, 8'h03, 1'b0, 1'b0);
        send(2'b00, 4'h4, 4'h5, 8'h09, 1'b0, 1'b0);
        in_valid = 1'b1; mode = 2'b00; op_a = 4'h6; op_b = 4'h7;
        pend.r = 8'h0D; pend.f = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_result", {24'd0, result}, 32'h03);
            tick();
        end
        out_ready = 1'b1;
        send(2'b00, 4'h6, 4'h7, 8'h0D, 1'b0, 1'b0);
        drain();

        // Clear coinciding with a completing ACC beat
        acc_clear();
        send(2'b10, 4'hF, 4'hF, 8'h1E, 1'b0, 1'b0);
        send(2'b10, 4'hF, 4'hF, 8'h3C, 1'b0, 1'b0);
        send(2'b10, 4'h2, 4'h2, 8'h40, 1'b0, 1'b0);
        drain();
        chk("acc_pre_40", {24'd0, acc_val}, 32'h40);
        send(2'b10, 4'h2, 4'h3, 8'h05, 1'b0, 1'b0);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        chk("clr_add_acc", {24'd0, acc_val}, 32'h05);
        drain();
        chk("clr_add_acc_hold", {24'd0, acc_val}, 32'h05);

        // Reset with both stages full and acc_val = 33
        acc_clear();
        send(2'b10, 4'hF, 4'hF, 8'h1E, 1'b0, 1'b0);
        send(2'b10, 4'hF, 4'h6, 8'h33, 1'b0, 1'b0);
        drain();
        chk("acc_pre_33", {24'd0, acc_val}, 32'h33);
        out_ready = 1'b0;
        send(2'b00, 4'h1, 4'h1, 8'h02, 1'b0, 1'b0);
        send(2'b00, 4'hF, 4'hF, 8'h1E, 1'b1, 1'b0);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_result", {24'd0, result}, 32'd0);
        chk("arst_flag", {31'd0, flag_c}, 32'd0);
        chk("arst_acc", {24'd0, acc_val}, 32'd0);
        sb.delete();
        nsent -= 2;
        tick();
        reset = 1'b0;
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        latency_add_f1();

        chk("sent_eq_retired", nret, nsent);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
